// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register file slice.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1
  } rd_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Byte address -> register index, with range and read-only band flags.
// Low address bits below the word size are ignored (unaligned accesses
// resolve to the containing word).
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RO   = 4,
  parameter int IDX_W    = clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic              ro
);

  localparam int ADDR_LSB = clog2(DATA_W / 8);

  logic [ADDR_W-1:0] word;

  // Any nonzero bit above the index range makes the word out of range.
  assign word  = addr >> ADDR_LSB;
  assign valid = (word < ADDR_W'(NUM_REGS));
  assign idx   = word[IDX_W-1:0];
  // One extra bit keeps the band base representable when NUM_RO is 0.
  assign ro    = valid && ({1'b0, idx} >= (IDX_W + 1)'(NUM_REGS - NUM_RO));

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with a read-only status band at the top
// of the index space and per-register write pulses toward the datapath.
//
// Handshakes: a transfer on any channel happens on the rising edge where
// both valid and ready are 1. The slave never waits for valid before
// raising ready; once bvalid/rvalid are up, response payload is held
// stable until the matching ready is seen.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 16,
  parameter int NUM_RO         = 4
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [AXI_ADDR_WIDTH-1:0]          s0_axi_awaddr,
  input  logic [2:0]                         s0_axi_awprot,
  input  logic                               s0_axi_awvalid,
  output logic                               s0_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]          s0_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]        s0_axi_wstrb,
  input  logic                               s0_axi_wvalid,
  output logic                               s0_axi_wready,
  output logic [1:0]                         s0_axi_bresp,
  output logic                               s0_axi_bvalid,
  input  logic                               s0_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]          s0_axi_araddr,
  input  logic [2:0]                         s0_axi_arprot,
  input  logic                               s0_axi_arvalid,
  output logic                               s0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]          s0_axi_rdata,
  output logic [1:0]                         s0_axi_rresp,
  output logic                               s0_axi_rvalid,
  input  logic                               s0_axi_rready,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_RO*AXI_DATA_WIDTH-1:0]   status_in,
  output logic [NUM_REGS-1:0]                wr_pulse
);

  localparam int DW      = AXI_DATA_WIDTH;
  localparam int STRB_W  = AXI_DATA_WIDTH / 8;
  localparam int IDX_W   = clog2(NUM_REGS);
  localparam int RO_BASE = NUM_REGS - NUM_RO;

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;
  logic      rst_q;

  logic                      aw_hs, w_hs, ar_hs, commit;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
  logic [DW-1:0]             w_data_q, wr_data;
  logic [STRB_W-1:0]         w_strb_q, wr_strb;
  logic [IDX_W-1:0]          wr_idx, rd_idx, rd_slot;
  logic                      wr_valid, wr_ro, rd_valid, rd_ro;
  logic [DW-1:0]             regs [NUM_REGS];
  logic                      unused_prot;

  assign unused_prot = ^{s0_axi_awprot, s0_axi_arprot};

  assign aw_hs = s0_axi_awvalid && s0_axi_awready;
  assign w_hs  = s0_axi_wvalid && s0_axi_wready;
  assign ar_hs = s0_axi_arvalid && s0_axi_arready;

  // Commit operands: latched half if it arrived earlier, live bus otherwise.
  assign wr_addr = (wr_state == W_HAVE_AW) ? aw_addr_q : s0_axi_awaddr;
  assign wr_data = (wr_state == W_HAVE_W) ? w_data_q : s0_axi_wdata;
  assign wr_strb = (wr_state == W_HAVE_W) ? w_strb_q : s0_axi_wstrb;
  assign rd_slot = rd_idx - IDX_W'(RO_BASE);

  axi_lite_addr_decode #(
    .ADDR_W   (AXI_ADDR_WIDTH),
    .DATA_W   (AXI_DATA_WIDTH),
    .NUM_REGS (NUM_REGS),
    .NUM_RO   (NUM_RO),
    .IDX_W    (IDX_W)
  ) u_aw_decode (
    .addr  (wr_addr),
    .idx   (wr_idx),
    .valid (wr_valid),
    .ro    (wr_ro)
  );

  axi_lite_addr_decode #(
    .ADDR_W   (AXI_ADDR_WIDTH),
    .DATA_W   (AXI_DATA_WIDTH),
    .NUM_REGS (NUM_REGS),
    .NUM_RO   (NUM_RO),
    .IDX_W    (IDX_W)
  ) u_ar_decode (
    .addr  (s0_axi_araddr),
    .idx   (rd_idx),
    .valid (rd_valid),
    .ro    (rd_ro)
  );

  // Readies stay low for the whole cycle following any reset edge.
  always_ff @(posedge aclk) begin
    rst_q <= areset;
  end

  // State registers for both FSMs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Write FSM next state; commit marks the edge both halves are in hand.
  always_comb begin
    wr_next = wr_state;
    commit  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_next = W_RESP;
          commit  = 1'b1;
        end else if (aw_hs) begin
          wr_next = W_HAVE_AW;
        end else if (w_hs) begin
          wr_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          wr_next = W_RESP;
          commit  = 1'b1;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          wr_next = W_RESP;
          commit  = 1'b1;
        end
      end
      W_RESP: begin
        if (s0_axi_bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Write FSM outputs.
  always_comb begin
    s0_axi_awready = 1'b0;
    s0_axi_wready  = 1'b0;
    s0_axi_bvalid  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s0_axi_awready = !rst_q;
        s0_axi_wready  = !rst_q;
      end
      W_HAVE_AW: s0_axi_wready  = !rst_q;
      W_HAVE_W:  s0_axi_awready = !rst_q;
      W_RESP:    s0_axi_bvalid  = 1'b1;
      default: begin
        s0_axi_awready = 1'b0;
        s0_axi_wready  = 1'b0;
      end
    endcase
  end

  // Read FSM next state.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (s0_axi_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    s0_axi_arready = 1'b0;
    s0_axi_rvalid  = 1'b0;
    case (rd_state)
      R_IDLE:  s0_axi_arready = !rst_q;
      R_DATA:  s0_axi_rvalid  = 1'b1;
      default: s0_axi_arready = 1'b0;
    endcase
  end

  // Hold whichever write half arrived first.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= s0_axi_awaddr;
      if (w_hs) begin
        w_data_q <= s0_axi_wdata;
        w_strb_q <= s0_axi_wstrb;
      end
    end
  end

  // Register update, write response and per-register pulse at commit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      s0_axi_bresp <= RESP_OKAY;
      wr_pulse     <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        if (wr_valid && !wr_ro) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
          wr_pulse[wr_idx] <= 1'b1;
          s0_axi_bresp     <= RESP_OKAY;
        end else begin
          s0_axi_bresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Read data capture; status band is sampled only at the AR edge.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s0_axi_rdata <= '0;
      s0_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      if (!rd_valid) begin
        s0_axi_rdata <= '0;
        s0_axi_rresp <= RESP_SLVERR;
      end else if (rd_ro) begin
        s0_axi_rdata <= status_in[int'(rd_slot)*DW +: DW];
        s0_axi_rresp <= RESP_OKAY;
      end else begin
        s0_axi_rdata <= regs[rd_idx];
        s0_axi_rresp <= RESP_OKAY;
      end
    end
  end

  // Flattened register view; read-only slots present zero.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    if (i >= RO_BASE) begin : g_ro
      assign reg_out[i*DW +: DW] = '0;
    end else begin : g_rw
      assign reg_out[i*DW +: DW] = regs[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile with default parameters
// (32-bit address/data, 16 registers, top 4 read-only).
module tb_axi_lite_regfile;

  logic         aclk;
  logic         areset;
  logic [31:0]  s0_axi_awaddr;
  logic [2:0]   s0_axi_awprot;
  logic         s0_axi_awvalid;
  logic         s0_axi_awready;
  logic [31:0]  s0_axi_wdata;
  logic [3:0]   s0_axi_wstrb;
  logic         s0_axi_wvalid;
  logic         s0_axi_wready;
  logic [1:0]   s0_axi_bresp;
  logic         s0_axi_bvalid;
  logic         s0_axi_bready;
  logic [31:0]  s0_axi_araddr;
  logic [2:0]   s0_axi_arprot;
  logic         s0_axi_arvalid;
  logic         s0_axi_arready;
  logic [31:0]  s0_axi_rdata;
  logic [1:0]   s0_axi_rresp;
  logic         s0_axi_rvalid;
  logic         s0_axi_rready;
  logic [511:0] reg_out;
  logic [127:0] status_in;
  logic [15:0]  wr_pulse;

  int n_checks;
  int n_errors;

  axi_lite_regfile dut (
    .aclk           (aclk),
    .areset         (areset),
    .s0_axi_awaddr  (s0_axi_awaddr),
    .s0_axi_awprot  (s0_axi_awprot),
    .s0_axi_awvalid (s0_axi_awvalid),
    .s0_axi_awready (s0_axi_awready),
    .s0_axi_wdata   (s0_axi_wdata),
    .s0_axi_wstrb   (s0_axi_wstrb),
    .s0_axi_wvalid  (s0_axi_wvalid),
    .s0_axi_wready  (s0_axi_wready),
    .s0_axi_bresp   (s0_axi_bresp),
    .s0_axi_bvalid  (s0_axi_bvalid),
    .s0_axi_bready  (s0_axi_bready),
    .s0_axi_araddr  (s0_axi_araddr),
    .s0_axi_arprot  (s0_axi_arprot),
    .s0_axi_arvalid (s0_axi_arvalid),
    .s0_axi_arready (s0_axi_arready),
    .s0_axi_rdata   (s0_axi_rdata),
    .s0_axi_rresp   (s0_axi_rresp),
    .s0_axi_rvalid  (s0_axi_rvalid),
    .s0_axi_rready  (s0_axi_rready),
    .reg_out        (reg_out),
    .status_in      (status_in),
    .wr_pulse       (wr_pulse)
  );

  // Clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // AW and W presented together, response collected.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [15:0] pulse);
    int n;
    s0_axi_awaddr  = addr;
    s0_axi_wdata   = data;
    s0_axi_wstrb   = strb;
    s0_axi_awvalid = 1'b1;
    s0_axi_wvalid  = 1'b1;
    n = 0;
    while (!(s0_axi_awready && s0_axi_wready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("write_ready_timeout", 1'b0, 1'b1);
    tick();
    s0_axi_awvalid = 1'b0;
    s0_axi_wvalid  = 1'b0;
    pulse = wr_pulse;
    n = 0;
    while (!s0_axi_bvalid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("bvalid_timeout", 1'b0, 1'b1);
    resp = s0_axi_bresp;
    s0_axi_bready = 1'b1;
    tick();
    s0_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    s0_axi_araddr  = addr;
    s0_axi_arvalid = 1'b1;
    n = 0;
    while (!s0_axi_arready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("arready_timeout", 1'b0, 1'b1);
    tick();
    s0_axi_arvalid = 1'b0;
    n = 0;
    while (!s0_axi_rvalid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("rvalid_timeout", 1'b0, 1'b1);
    data = s0_axi_rdata;
    resp = s0_axi_rresp;
    s0_axi_rready = 1'b1;
    tick();
    s0_axi_rready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, s0_axi_awready, 1'b0);
    check({tag, "_wready"},  s0_axi_wready,  1'b0);
    check({tag, "_arready"}, s0_axi_arready, 1'b0);
    check({tag, "_bvalid"},  s0_axi_bvalid,  1'b0);
    check({tag, "_rvalid"},  s0_axi_rvalid,  1'b0);
    check({tag, "_bresp"},   s0_axi_bresp,   2'b00);
    check({tag, "_rresp"},   s0_axi_rresp,   2'b00);
    check({tag, "_rdata"},   s0_axi_rdata,   32'h0);
    check({tag, "_wr_pulse"}, wr_pulse,      16'h0);
    check({tag, "_reg_out"}, reg_out,        512'h0);
  endtask

  logic [1:0]   resp;
  logic [15:0]  pulse;
  logic [31:0]  rdata;
  logic [511:0] exp_regs;

  initial begin
    n_checks = 0;
    n_errors = 0;
    areset = 1'b1;
    s0_axi_awaddr = '0; s0_axi_awprot = '0; s0_axi_awvalid = 1'b0;
    s0_axi_wdata = '0;  s0_axi_wstrb = '0;  s0_axi_wvalid = 1'b0;
    s0_axi_bready = 1'b0;
    s0_axi_araddr = '0; s0_axi_arprot = '0; s0_axi_arvalid = 1'b0;
    s0_axi_rready = 1'b0;
    status_in = {32'h5A5A0003, 32'h0, 32'h0, 32'hCAFE0001};
    exp_regs = '0;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("rst");
    areset = 1'b0;
    tick();
    check("post_rst_awready", s0_axi_awready, 1'b1);
    check("post_rst_wready",  s0_axi_wready,  1'b1);
    check("post_rst_arready", s0_axi_arready, 1'b1);

    // AW+W together to reg2, full strobe
    s0_axi_awaddr = 32'h08; s0_axi_wdata = 32'hA5A5A5A5; s0_axi_wstrb = 4'hF;
    s0_axi_awvalid = 1'b1; s0_axi_wvalid = 1'b1;
    tick();
    s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0;
    check("t1_bvalid",   s0_axi_bvalid, 1'b1);
    check("t1_bresp",    s0_axi_bresp,  2'b00);
    check("t1_pulse",    wr_pulse,      16'h0004);
    check("t1_reg2",     reg_out[2*32 +: 32], 32'hA5A5A5A5);
    check("t1_awready",  s0_axi_awready, 1'b0);
    tick();
    check("t1_pulse_one_cycle", wr_pulse, 16'h0000);
    check("t1_bvalid_hold", s0_axi_bvalid, 1'b1);
    s0_axi_bready = 1'b1;
    tick();
    s0_axi_bready = 1'b0;
    check("t1_bvalid_clr", s0_axi_bvalid, 1'b0);
    do_read(32'h08, rdata, resp);
    check("t1_rdata", rdata, 32'hA5A5A5A5);
    check("t1_rresp", resp,  2'b00);
    exp_regs[2*32 +: 32] = 32'hA5A5A5A5;

    // W first, AW three cycles later; lanes 0 and 2 only
    s0_axi_wdata = 32'h11223344; s0_axi_wstrb = 4'h5; s0_axi_wvalid = 1'b1;
    tick();
    s0_axi_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("t2_wready_low", s0_axi_wready, 1'b0);
      check("t2_awready",    s0_axi_awready, 1'b1);
      check("t2_no_bvalid",  s0_axi_bvalid, 1'b0);
      tick();
    end
    check("t2_wready_low_last", s0_axi_wready, 1'b0);
    s0_axi_awaddr = 32'h0C; s0_axi_awvalid = 1'b1;
    tick();
    s0_axi_awvalid = 1'b0;
    check("t2_bvalid", s0_axi_bvalid, 1'b1);
    check("t2_bresp",  s0_axi_bresp,  2'b00);
    check("t2_reg3",   reg_out[3*32 +: 32], 32'h00220044);
    check("t2_pulse",  wr_pulse, 16'h0008);
    s0_axi_bready = 1'b1;
    tick();
    s0_axi_bready = 1'b0;
    exp_regs[3*32 +: 32] = 32'h00220044;

    // Read-only band: write rejected, read returns status
    do_write(32'h30, 32'hFFFFFFFF, 4'hF, resp, pulse);
    check("t3_bresp", resp,  2'b10);
    check("t3_pulse", pulse, 16'h0000);
    do_read(32'h30, rdata, resp);
    check("t3_rdata", rdata, 32'hCAFE0001);
    check("t3_rresp", resp,  2'b00);
    do_read(32'h3C, rdata, resp);
    check("t3_rdata_last", rdata, 32'h5A5A0003);
    check("t3_rresp_last", resp,  2'b00);

    // Out-of-range accesses
    do_write(32'h40, 32'hDEADBEEF, 4'hF, resp, pulse);
    check("t4_bresp", resp,  2'b10);
    check("t4_pulse", pulse, 16'h0000);
    do_read(32'h40, rdata, resp);
    check("t4_rdata", rdata, 32'h0);
    check("t4_rresp", resp,  2'b10);
    do_read(32'h8000_0008, rdata, resp);
    check("t4_upper_rdata", rdata, 32'h0);
    check("t4_upper_rresp", resp,  2'b10);
    check("t4_regs", reg_out, exp_regs);

    // Zero strobe still pulses but leaves data unchanged
    do_write(32'h14, 32'hFFFFFFFF, 4'h0, resp, pulse);
    check("t5_zstrb_bresp", resp,  2'b00);
    check("t5_zstrb_pulse", pulse, 16'h0020);
    check("t5_zstrb_regs",  reg_out, exp_regs);

    // Backpressure with AR coinciding with a commit to the same register
    s0_axi_awaddr = 32'h08; s0_axi_wdata = 32'h12345678; s0_axi_wstrb = 4'h3;
    s0_axi_araddr = 32'h08;
    s0_axi_awvalid = 1'b1; s0_axi_wvalid = 1'b1; s0_axi_arvalid = 1'b1;
    tick();
    s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0; s0_axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_bvalid",  s0_axi_bvalid,  1'b1);
      check("t5_bresp",   s0_axi_bresp,   2'b00);
      check("t5_rvalid",  s0_axi_rvalid,  1'b1);
      check("t5_rdata",   s0_axi_rdata,   32'hA5A5A5A5);
      check("t5_rresp",   s0_axi_rresp,   2'b00);
      check("t5_awready", s0_axi_awready, 1'b0);
      check("t5_wready",  s0_axi_wready,  1'b0);
      check("t5_arready", s0_axi_arready, 1'b0);
      tick();
    end
    exp_regs[2*32 +: 32] = 32'hA5A55678;
    check("t5_regs", reg_out, exp_regs);
    s0_axi_bready = 1'b1; s0_axi_rready = 1'b1;
    tick();
    s0_axi_bready = 1'b0; s0_axi_rready = 1'b0;
    check("t5_bvalid_clr",  s0_axi_bvalid,  1'b0);
    check("t5_rvalid_clr",  s0_axi_rvalid,  1'b0);
    check("t5_awready_up",  s0_axi_awready, 1'b1);
    check("t5_arready_up",  s0_axi_arready, 1'b1);

    // Reset while holding only the address half
    s0_axi_awaddr = 32'h10; s0_axi_awvalid = 1'b1;
    tick();
    s0_axi_awvalid = 1'b0;
    check("t6_have_aw_awready", s0_axi_awready, 1'b0);
    check("t6_have_aw_wready",  s0_axi_wready,  1'b1);
    areset = 1'b1;
    tick();
    check_reset_outputs("t6_rst");
    areset = 1'b0;
    tick();
    check("t6_post_awready", s0_axi_awready, 1'b1);
    check("t6_post_wready",  s0_axi_wready,  1'b1);
    do_write(32'h10, 32'h600DCAFE, 4'hF, resp, pulse);
    check("t6_bresp", resp,  2'b00);
    check("t6_pulse", pulse, 16'h0010);
    exp_regs = '0;
    exp_regs[4*32 +: 32] = 32'h600DCAFE;
    check("t6_regs", reg_out, exp_regs);
    do_read(32'h10, rdata, resp);
    check("t6_rdata", rdata, 32'h600DCAFE);
    check("t6_rresp", resp,  2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- Parametrised AXI4-Lite slave register file; successor of the fixed 4-register slave.
- Depth is configurable, and a configurable top band of the register space is read-only status driven from fabric.
- Byte strobes are honoured, and AW and W are accepted independently in either order.
- Decode errors and writes to read-only registers return SLVERR.
- Each write raises a per-register one-cycle pulse toward the datapath; the block sits between the PS interconnect and the compute blocks' control inputs.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 32, data width; 32 or 64 only.
- NUM_REGS, 16, total register count; at least 2.
- NUM_RO, 4, count of read-only registers, indices NUM_REGS-NUM_RO .. NUM_REGS-1; range 0 .. NUM_REGS-1.

Ports:
- aclk  in  1  clock
- areset  in  1  one clock; reset is synchronous and active-high
- s0_axi_awaddr  in  AXI_ADDR_WIDTH  write address
- s0_axi_awprot  in  3  ignored
- s0_axi_awvalid / s0_axi_awready  in / out  1  AW handshake
- s0_axi_wdata  in  AXI_DATA_WIDTH  write data
- s0_axi_wstrb  in  AXI_DATA_WIDTH/8  byte strobes
- s0_axi_wvalid / s0_axi_wready  in / out  1  W handshake
- s0_axi_bresp  out  2  write response
- s0_axi_bvalid / s0_axi_bready  out / in  1  B handshake
- s0_axi_araddr  in  AXI_ADDR_WIDTH  read address
- s0_axi_arprot  in  3  ignored
- s0_axi_arvalid / s0_axi_arready  in / out  1  AR handshake
- s0_axi_rdata  out  AXI_DATA_WIDTH  read data, registered
- s0_axi_rresp  out  2  read response
- s0_axi_rvalid / s0_axi_rready  out / in  1  R handshake
- reg_out  out  NUM_REGS*AXI_DATA_WIDTH  flattened register contents; RO slots read 0
- status_in  in  NUM_RO*AXI_DATA_WIDTH  fabric status; slot k maps to index NUM_REGS-NUM_RO+k
- wr_pulse  out  NUM_REGS  one-cycle strobe per successfully written register

Behaviour:
- Address decode:
  - ADDR_LSB = log2(AXI_DATA_WIDTH/8); idx = addr >> ADDR_LSB.
  - Invalid if idx >= NUM_REGS, including any nonzero upper address bit.
  - Write-protected if idx lies in the RO band.
- Reset (areset=1 at a clock edge):
  - All registers = 0.
  - awready = wready = arready = 0; bvalid = rvalid = 0.
  - bresp = rresp = 00; rdata = 0; wr_pulse = 0.
  - An in-flight transaction is dropped with no response.
  - First cycle after reset: FSMs in IDLE, all readies = 1.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - awready = 1 in W_IDLE and W_HAVE_W; wready = 1 in W_IDLE and W_HAVE_AW; both 0 in W_RESP.
  - W_IDLE: AW only -> latch addr, go W_HAVE_AW. W only -> latch data and strb, go W_HAVE_W. Both in the same cycle -> commit, go W_RESP.
  - W_HAVE_AW + W handshake, or W_HAVE_W + AW handshake -> commit, go W_RESP.
  - Commit edge: lane i of reg[idx] updated only if strb[i]=1. bvalid <= 1; bresp = 00 (OKAY) or 10 (SLVERR if invalid or RO, no register change).
  - wr_pulse[idx] = 1 for exactly the cycle after the commit edge, OKAY writes only; wr_pulse is asserted even when strb = 0.
  - W_RESP: bvalid held until bready; on B handshake -> W_IDLE. Minimum write turnaround is 2 cycles.
- Read FSM states: R_IDLE (arready=1, rvalid=0), R_DATA (arready=0, rvalid=1).
  - AR handshake: rdata <= reg[idx], or status_in slot for RO idx. Invalid idx gives rdata = 0, rresp = 10; otherwise rresp = 00.
  - rdata/rresp stable while rvalid && !rready. R handshake -> R_IDLE.
- Simultaneous events:
  - Read and write FSMs run independently.
  - AR edge coinciding with a write commit to the same idx returns the pre-write value.
  - status_in is sampled only at the AR edge.
- Illegal state encoding in either FSM -> IDLE with readies re-raised, no response generated.

Decomposition:
- Package axi_lite_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - write/read FSM state encodings
  - clog2 function
- Sub-module axi_lite_addr_decode (combinational): addr -> idx, valid, ro. Instantiated once for AW and once for AR.

Test Plan:
- Reset then AW+W together, addr 0x08, data 0xA5A5A5A5, strb 0xF -> bresp 00; reg_out slot 2 = 0xA5A5A5A5; wr_pulse = 0x0004 for one cycle; AR 0x08 returns 0xA5A5A5A5, rresp 00.
- W first (data 0x11223344, strb 0x5), AW 0x0C three cycles later, over reg3 = 0 -> reg3 = 0x00220044, bvalid only after the AW edge; wready = 0 while in W_HAVE_W.
- Write to RO index 12 (addr 0x30) with status_in slot0 = 0xCAFE0001 -> bresp 10, no wr_pulse; read 0x30 returns 0xCAFE0001, rresp 00.
- Read and write to out-of-range addr 0x40 (NUM_REGS=16) -> rresp 10, rdata 0, bresp 10, no register changes.
- bready and rready held low 5 cycles -> bvalid/rvalid, data and resp stable; awready, wready and arready stay 0 until each handshake completes.
- areset asserted while in W_HAVE_AW -> next cycle all outputs at reset values; a subsequent full write completes normally.
